// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default word-address and data widths
//   slot_state_e            : response slot state (S_EMPTY / S_FULL)
//   P_CPU / P_LDR           : requester ids (CPU load/store = 0, debug/loader = 1)
package dmem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_e;

    localparam logic P_CPU = 1'b0;
    localparam logic P_LDR = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk    in  clock
//   rst    in  synchronous active-high reset (pointer -> port 0)
//   valid  in  [1:0] request lines
//   enable in  grants allowed this cycle
//   grant  out [1:0] one-hot grant (all zero when disabled or idle)
// The pointer names the preferred port under contention and toggles on every grant.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant
);

    logic ptr_q, ptr_d;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            unique case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (ptr_q == P_LDR) ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign ptr_d = (|grant) ? ~ptr_q : ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= P_CPU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the CPU (port 0) and the loader (port 1).
//   clk, rst                    clock, synchronous active-high reset
//   reqN_valid/we/addr/wdata    request from port N; reqN_ready = accepted this cycle
//   rspN_valid/rdata, rspN_ready one-entry response slot per access (write acks carry 0)
//   mem_read/mem_write/mem_addr/mem_wdata/mem_rdata  memory interface (comb read)
// One access may issue per cycle; a new issue is allowed when the slot is empty or its
// current response is being consumed in the same cycle.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    input  logic              rsp1_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    slot_state_e       state_q, state_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [1:0] rsp_ready;
    logic [1:0] grant;
    logic       consume, can_issue, issue, win, win_we;

    assign rsp_ready = {rsp1_ready, rsp0_ready};
    // FULL implies the owner's rsp_valid is high, so only its ready matters.
    assign consume   = (state_q == S_FULL) && rsp_ready[owner_q];
    assign can_issue = (state_q == S_EMPTY) || consume;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .valid  ({req1_valid, req0_valid}),
        .enable (can_issue && !rst),
        .grant  (grant)
    );

    assign issue  = |grant;
    assign win    = grant[1];
    assign win_we = win ? req1_we : req0_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            owner_q <= P_CPU;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rdata_d = rdata_q;
        if (issue) begin
            state_d = S_FULL;
            owner_d = win;
            rdata_d = win_we ? '0 : mem_rdata;
        end else if (consume) begin
            state_d = S_EMPTY;
        end
    end

    always_comb begin
        req0_ready = grant[0];
        req1_ready = grant[1];
        mem_read   = issue && !win_we;
        mem_write  = issue && win_we;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (issue) begin
            mem_addr  = win ? req1_addr  : req0_addr;
            mem_wdata = win ? req1_wdata : req0_wdata;
        end
        rsp0_valid = (state_q == S_FULL) && (owner_q == P_CPU);
        rsp1_valid = (state_q == S_FULL) && (owner_q == P_LDR);
        rsp0_rdata = rsp0_valid ? rdata_q : '0;
        rsp1_rdata = rsp1_valid ? rdata_q : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_we, req0_ready;
    logic [5:0]  req0_addr;
    logic [31:0] req0_wdata;
    logic        req1_valid, req1_we, req1_ready;
    logic [5:0]  req1_addr;
    logic [31:0] req1_wdata;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        mem_read, mem_write;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    dmem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .rsp1_ready (rsp1_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Device memory: combinational read, posedge write, preloaded on the first edge.
    logic [31:0] mem [64];
    logic        loaded = 1'b0;
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
            mem[0] <= 32'd1;
            mem[1] <= 32'd5;
            mem[2] <= 32'd25;
            loaded <= 1'b1;
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain sequential memory, per-port response queues, toggling preference.
    logic [31:0] ref_mem [64];
    logic        ref_init = 1'b0;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic        ptr_m = 1'b0;
    logic        acc0 = 1'b0, acc1 = 1'b0;

    always @(negedge clk) begin
        logic full, owner, cons, can, g0, g1, gw;
        logic [31:0] exp_val;
        if (!ref_init) begin
            for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
            ref_mem[0] = 32'd1;
            ref_mem[1] = 32'd5;
            ref_mem[2] = 32'd25;
            ref_init = 1'b1;
        end
        if (rst) begin
            chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
            chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
            chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
            chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
            q0.delete();
            q1.delete();
            ptr_m = 1'b0;
            acc0 = 1'b0;
            acc1 = 1'b0;
        end else begin
            full  = (q0.size() + q1.size()) != 0;
            owner = q1.size() != 0;
            cons  = full && (owner ? rsp1_ready : rsp0_ready);
            chk("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, full && !owner});
            chk("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, full && owner});
            if (full && !owner) begin
                chk("rsp0_rdata", rsp0_rdata, q0[0]);
                if (cons) void'(q0.pop_front());
            end
            if (full && owner) begin
                chk("rsp1_rdata", rsp1_rdata, q1[0]);
                if (cons) void'(q1.pop_front());
            end
            can = !full || cons;
            g0 = 1'b0;
            g1 = 1'b0;
            if (can) begin
                if (req0_valid && req1_valid) begin
                    g0 = !ptr_m;
                    g1 = ptr_m;
                end else begin
                    g0 = req0_valid;
                    g1 = req1_valid;
                end
            end
            gw = g1 ? req1_we : req0_we;
            chk("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
            chk("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
            chk("mem_read", {31'd0, mem_read}, {31'd0, (g0 || g1) && !gw});
            chk("mem_write", {31'd0, mem_write}, {31'd0, (g0 || g1) && gw});
            if (g0 || g1) begin
                chk("mem_addr", {26'd0, mem_addr}, {26'd0, g1 ? req1_addr : req0_addr});
                if (gw) chk("mem_wdata", mem_wdata, g1 ? req1_wdata : req0_wdata);
                if (gw) begin
                    ref_mem[g1 ? req1_addr : req0_addr] = g1 ? req1_wdata : req0_wdata;
                    exp_val = 32'd0;
                end else begin
                    exp_val = ref_mem[g1 ? req1_addr : req0_addr];
                end
                if (g1) q1.push_back(exp_val);
                else    q0.push_back(exp_val);
                ptr_m = ~ptr_m;
            end else begin
                chk("idle_mem_addr", {26'd0, mem_addr}, 32'd0);
                chk("idle_mem_wdata", mem_wdata, 32'd0);
            end
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
        end
    end

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic we, input logic [5:0] a, input logic [31:0] d);
        req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    endtask

    task automatic set1(input logic v, input logic we, input logic [5:0] a, input logic [31:0] d);
        req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    endtask

    initial begin
        int g0n, g1n, strobes;
        rst = 1'b1;
        set0(1'b0, 1'b0, 6'd0, 32'd0);
        set1(1'b0, 1'b0, 6'd0, 32'd0);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        to_drive();
        to_drive();
        rst = 1'b0;
        to_neg();
        chk("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("reset_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        chk("reset_rsp0_rdata", rsp0_rdata, 32'd0);

        // Write then read back on port 0.
        to_drive();
        set0(1'b1, 1'b1, 6'd3, 32'hDEADBEEF);
        to_neg();
        chk("t1_write_strobe", {31'd0, mem_write}, 32'd1);
        to_drive();
        set0(1'b1, 1'b0, 6'd3, 32'd0);
        to_neg();
        chk("t1_write_ack", {31'd0, rsp0_valid}, 32'd1);
        chk("t1_write_pulse", {31'd0, mem_write}, 32'd0);
        to_drive();
        set0(1'b0, 1'b0, 6'd0, 32'd0);
        to_neg();
        chk("t1_readback", rsp0_rdata, 32'hDEADBEEF);

        // Contention: port 0 first, port 1 next cycle.
        to_drive();
        set0(1'b1, 1'b0, 6'd0, 32'd0);
        set1(1'b1, 1'b0, 6'd1, 32'd0);
        to_neg();
        chk("t2_first_p0", {30'd0, req1_ready, req0_ready}, 32'd1);
        to_drive();
        set0(1'b0, 1'b0, 6'd0, 32'd0);
        to_neg();
        chk("t2_second_p1", {31'd0, req1_ready}, 32'd1);
        chk("t2_rsp0", rsp0_rdata, 32'd1);
        to_drive();
        set1(1'b0, 1'b0, 6'd0, 32'd0);
        to_neg();
        chk("t2_rsp1", rsp1_rdata, 32'd5);

        // Fairness over 8 cycles of continuous contention.
        to_drive();
        set0(1'b1, 1'b0, 6'd4, 32'd0);
        set1(1'b1, 1'b0, 6'd5, 32'd0);
        g0n = 0;
        g1n = 0;
        for (int i = 0; i < 8; i++) begin
            to_neg();
            g0n += int'(req0_ready);
            g1n += int'(req1_ready);
            strobes = int'(mem_read) + int'(mem_write);
            chk("t3_one_strobe", strobes, 32'd1);
            to_drive();
        end
        set0(1'b0, 1'b0, 6'd0, 32'd0);
        set1(1'b0, 1'b0, 6'd0, 32'd0);
        chk("t3_grants_p0", g0n, 32'd4);
        chk("t3_grants_p1", g1n, 32'd4);
        to_neg();

        // Backpressure on port 0 while port 1 waits.
        to_drive();
        rsp0_ready = 1'b0;
        set0(1'b1, 1'b0, 6'd2, 32'd0);
        set1(1'b1, 1'b0, 6'd6, 32'd0);
        to_neg();
        chk("t4_p0_grant", {31'd0, req0_ready}, 32'd1);
        to_drive();
        set0(1'b0, 1'b0, 6'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            to_neg();
            chk("t4_p1_blocked", {31'd0, req1_ready}, 32'd0);
            chk("t4_no_strobe", {30'd0, mem_read, mem_write}, 32'd0);
            chk("t4_hold", rsp0_rdata, 32'd25);
            to_drive();
        end
        rsp0_ready = 1'b1;
        to_neg();
        chk("t4_p1_released", {31'd0, req1_ready}, 32'd1);
        to_drive();
        set1(1'b0, 1'b0, 6'd0, 32'd0);
        to_neg();

        // Reset while the slot is full and both ports request writes.
        to_drive();
        rsp0_ready = 1'b0;
        set0(1'b1, 1'b0, 6'd0, 32'd0);
        set1(1'b1, 1'b1, 6'd20, 32'd99);
        to_drive();
        set0(1'b1, 1'b1, 6'd21, 32'h55);
        rst = 1'b1;
        to_neg();
        chk("t5_no_write_in_rst", {31'd0, mem_write}, 32'd0);
        to_drive();
        rst = 1'b0;
        rsp0_ready = 1'b1;
        to_neg();
        chk("t5_rsp_cleared", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("t5_first_grant_p0", {30'd0, req1_ready, req0_ready}, 32'd1);
        to_drive();
        set0(1'b0, 1'b0, 6'd0, 32'd0);
        set1(1'b0, 1'b0, 6'd0, 32'd0);
        to_neg();
        to_drive();
        to_neg();

        // Back-to-back write then read of the same address on port 1.
        to_drive();
        set1(1'b1, 1'b1, 6'd10, 32'd7);
        to_drive();
        set1(1'b1, 1'b0, 6'd10, 32'd0);
        to_drive();
        set1(1'b0, 1'b0, 6'd0, 32'd0);
        to_neg();
        chk("t6_raw", rsp1_rdata, 32'd7);

        // Randomized traffic; a request is held until accepted.
        for (int i = 0; i < 400; i++) begin
            to_drive();
            if (!(req0_valid && !acc0)) begin
                set0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     6'($urandom_range(0, 15)), $urandom());
            end
            if (!(req1_valid && !acc1)) begin
                set1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     6'($urandom_range(0, 15)), $urandom());
            end
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
        end
        to_drive();
        set0(1'b0, 1'b0, 6'd0, 32'd0);
        set1(1'b0, 1'b0, 6'd0, 32'd0);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        repeat (4) to_drive();
        to_neg();
        chk("drain_empty", q0.size() + q1.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
